unsigned_calc_solver_v: RTL

Sequential inverse of the unsigned 7X − 3Y + 6Z calculator: given an 8-bit result code F, it searches the 4096 unsigned 4-bit operand triples (X, Y, Z) and returns the first triple whose calculator output equals F. The match uses the same 8-bit two's-complement wrap as the calculator. The block sits downstream of the calculator in the lab datapath and is used to decode/verify result codes. It runs one candidate per clock behind a start/done handshake.

---
 rtl/unsigned_calc_solver_v.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/unsigned_calc_solver_v.sv
// ---------------------------------------------------------------------------
// unsigned_calc_solver_v
//
// Sequential inverse of the unsigned 7X - 3Y + 6Z calculator. Given an 8-bit
// result code it walks all 4096 unsigned 4-bit operand triples (X, Y, Z), one
// candidate per clock. It reports the first triple whose calculator output,
// wrapped to 8 bits, equals the code.
//
// Candidate order is k = X*256 + Z*16 + Y. Y advances fastest, then Z, then X.
// A running accumulator holds the exact value 7X - 3Y + 6Z for the current
// candidate, so each step only needs one constant add.
//
// Ports
//   i_clk    : sole clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : request a search (sampled only in IDLE)
//   i_abort  : cancel a running search (sampled only in SEARCH)
//   i_fu     : 8-bit target code, captured when start is accepted
//   o_busy   : high while searching
//   o_done   : one-cycle pulse when a search completes
//   o_found  : match found; held until the next accepted start
//   o_au     : X of the match (0 if none)
//   o_bu     : Y of the match (0 if none)
//   o_cu     : Z of the match (0 if none)
// ---------------------------------------------------------------------------
module unsigned_calc_solver_v (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_fu,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_found,
  output logic [3:0] o_au,
  output logic [3:0] o_bu,
  output logic [3:0] o_cu
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Accumulator step constants. Each is the change in 7X - 3Y + 6Z when
  // moving to the next candidate in search order.
  localparam logic signed [8:0] STEP_Y = -9'sd3;   // Y+1
  localparam logic signed [8:0] STEP_Z = 9'sd51;   // Z+1, Y 15 -> 0
  localparam logic signed [8:0] STEP_X = -9'sd38;  // X+1, Y,Z 15 -> 0

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        x_r, y_r, z_r;
  logic [3:0]        x_s, y_s, z_s;
  logic signed [8:0] acc_r;
  logic signed [8:0] acc_s;
  logic [7:0]        f_r;
  logic [7:0]        f_s;
  logic              busy_r, done_r, found_r;
  logic              busy_s, done_s, found_s;
  logic [3:0]        au_r, bu_r, cu_r;
  logic [3:0]        au_s, bu_s, cu_s;

  logic              match_s;
  logic              last_s;
  logic              y_max_s;
  logic              z_max_s;

  // Compare only the low 8 bits, reproducing the calculator's output wrap.
  assign match_s = (acc_r[7:0] == f_r);
  assign y_max_s = (y_r == 4'd15);
  assign z_max_s = (z_r == 4'd15);
  assign last_s  = (x_r == 4'd15) && y_max_s && z_max_s;

  // Next-state and next-register computation for the search FSM.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    z_s     = z_r;
    acc_s   = acc_r;
    f_s     = f_r;
    found_s = found_r;
    au_s    = au_r;
    bu_s    = bu_r;
    cu_s    = cu_r;

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          f_s     = i_fu;
          x_s     = 4'd0;
          y_s     = 4'd0;
          z_s     = 4'd0;
          acc_s   = 9'sd0;
          found_s = 1'b0;
          au_s    = 4'd0;
          bu_s    = 4'd0;
          cu_s    = 4'd0;
          state_s = ST_SEARCH;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEARCH: begin
        if (i_abort) begin
          // Outputs keep the values cleared at start; no completion pulse.
          state_s = ST_IDLE;
        end else if (match_s) begin
          found_s = 1'b1;
          au_s    = x_r;
          bu_s    = y_r;
          cu_s    = z_r;
          state_s = ST_DONE;
        end else if (last_s) begin
          found_s = 1'b0;
          state_s = ST_DONE;
        end else if (!y_max_s) begin
          y_s   = y_r + 4'd1;
          acc_s = acc_r + STEP_Y;
        end else if (!z_max_s) begin
          y_s   = 4'd0;
          z_s   = z_r + 4'd1;
          acc_s = acc_r + STEP_Z;
        end else begin
          y_s   = 4'd0;
          z_s   = 4'd0;
          x_s   = x_r + 4'd1;
          acc_s = acc_r + STEP_X;
        end
      end

      ST_DONE: begin
        // Start is deliberately ignored here; the FSM always rests in IDLE
        // for at least one cycle before a new search.
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Status outputs are registered versions of the state being entered.
    busy_s = (state_s == ST_SEARCH);
    done_s = (state_s == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      x_r     <= 4'd0;
      y_r     <= 4'd0;
      z_r     <= 4'd0;
      acc_r   <= 9'sd0;
      f_r     <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      au_r    <= 4'd0;
      bu_r    <= 4'd0;
      cu_r    <= 4'd0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      z_r     <= z_s;
      acc_r   <= acc_s;
      f_r     <= f_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      found_r <= found_s;
      au_r    <= au_s;
      bu_r    <= bu_s;
      cu_r    <= cu_s;
    end
  end

  assign o_busy  = busy_r;
  assign o_done  = done_r;
  assign o_found = found_r;
  assign o_au    = au_r;
  assign o_bu    = bu_r;
  assign o_cu    = cu_r;

endmodule
